// File: rtl/gpio_port.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : gpio_port
// Purpose  : Memory-mapped GPIO port. It has per-pin direction, an output
//            latch, a synchronised and debounced input path, and rise/fall
//            edge detection with write-1-to-clear pending flags that drive a
//            registered interrupt line.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_port #(
  parameter int          NUM_PINS  = 8,
  parameter logic [23:0] BASE_ADDR = 24'h002060,
  parameter int          DEBOUNCE  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_ce,
  input  logic                bus_write,
  input  logic                bus_read,
  input  logic [23:0]         bus_address_in,
  input  logic [7:0]          bus_data_in,
  output logic [7:0]          bus_data_out,
  input  logic [NUM_PINS-1:0] pin_in,
  output logic [NUM_PINS-1:0] pin_out,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic                irq
);

  localparam int          CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [23:0] OFF_DIR  = 24'd0;
  localparam logic [23:0] OFF_DATA = 24'd1;
  localparam logic [23:0] OFF_RISE = 24'd2;
  localparam logic [23:0] OFF_FALL = 24'd3;
  localparam logic [23:0] OFF_PEND = 24'd4;

  logic [NUM_PINS-1:0] dir_reg;
  logic [NUM_PINS-1:0] data_reg;
  logic [NUM_PINS-1:0] rise_en;
  logic [NUM_PINS-1:0] fall_en;
  logic [NUM_PINS-1:0] pending;
  logic [NUM_PINS-1:0] sync1;
  logic [NUM_PINS-1:0] sync2;
  logic [NUM_PINS-1:0] stable;
  logic [NUM_PINS-1:0] stable_nxt;
  logic [NUM_PINS-1:0] rise_det;
  logic [NUM_PINS-1:0] fall_det;
  logic [NUM_PINS-1:0] pend_set;
  logic [NUM_PINS-1:0] pend_clr;
  logic [NUM_PINS-1:0] wdata;
  logic [23:0]         offset;
  logic                sel_dir;
  logic                sel_data;
  logic                sel_rise;
  logic                sel_fall;
  logic                sel_pend;
  logic                wr_en;

  // Register offsets are found by subtracting the base address. The
  // subtraction wraps at 24 bits, so an address below the base gives a large
  // offset and selects nothing.
  assign offset   = bus_address_in - BASE_ADDR;
  assign sel_dir  = (offset == OFF_DIR);
  assign sel_data = (offset == OFF_DATA);
  assign sel_rise = (offset == OFF_RISE);
  assign sel_fall = (offset == OFF_FALL);
  assign sel_pend = (offset == OFF_PEND);
  assign wr_en    = clk_ce & bus_write;
  assign wdata    = bus_data_in[NUM_PINS-1:0];

  assign pin_oe  = dir_reg;
  assign pin_out = data_reg;

  // Read mux. Unused upper bits read as 0. The output is driven only during
  // a read of a decoded address, so several ports can share an OR-ed bus.
  always_comb begin
    bus_data_out = 8'h00;
    if (bus_read) begin
      if (sel_dir)  bus_data_out[NUM_PINS-1:0] = dir_reg;
      if (sel_data) bus_data_out[NUM_PINS-1:0] = (dir_reg & data_reg) | (~dir_reg & stable);
      if (sel_rise) bus_data_out[NUM_PINS-1:0] = rise_en;
      if (sel_fall) bus_data_out[NUM_PINS-1:0] = fall_en;
      if (sel_pend) bus_data_out[NUM_PINS-1:0] = pending;
    end
  end

  // Plain-store configuration registers, written through the bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_reg  <= '0;
      data_reg <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr_en) begin
      if (sel_dir)  dir_reg  <= wdata;
      if (sel_data) data_reg <= wdata;
      if (sel_rise) rise_en  <= wdata;
      if (sel_fall) fall_en  <= wdata;
    end
  end

  // Two-flop metastability synchronizer. It runs on every clock, whatever
  // the state of clk_ce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // Each pin has its own debouncer. Each one computes the next value of its
  // stable bit.
  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    if (DEBOUNCE == 0) begin : g_bypass
      assign stable_nxt[i] = sync2[i];
    end else begin : g_debounce
      logic [CNT_W-1:0] cnt;
      logic             cnt_full;

      assign cnt_full      = (cnt == CNT_W'(DEBOUNCE - 1));
      assign stable_nxt[i] = (sync2[i] != stable[i] && cnt_full) ? sync2[i] : stable[i];

      // The count restarts when the input agrees with the stable bit. It
      // also restarts on the sample that accepts a new stable value.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt <= '0;
        end else if (clk_ce) begin
          if (sync2[i] == stable[i] || cnt_full) cnt <= '0;
          else                                   cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Stable (debounced) input bits advance only on enabled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      stable <= '0;
    else if (clk_ce) stable <= stable_nxt;
  end

  // An edge is a change of a stable bit, and counts only on input pins. The
  // stable bit tracks the pad even while a pin is an output. So turning a
  // pin back into an input does not create a false edge.
  assign rise_det = stable_nxt & ~stable & ~dir_reg;
  assign fall_det = ~stable_nxt & stable & ~dir_reg;
  assign pend_set = (rise_det & rise_en) | (fall_det & fall_en);
  assign pend_clr = (wr_en && sel_pend) ? wdata : '0;

  // Pending flags are write-1-to-clear. A new edge wins over a clear in the
  // same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pending <= '0;
    else if (clk_ce) pending <= (pending & ~pend_clr) | pend_set;
  end

  // The interrupt is registered from the pending flags, one enabled cycle
  // later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      irq <= 1'b0;
    else if (clk_ce) irq <= |(pending & (rise_en | fall_en));
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_port.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_gpio_port
// Purpose  : Directed self-checking bench for gpio_port (default parameters)
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_port;

  localparam logic [23:0] BASE = 24'h002060;
  localparam int A_DIR = 0, A_DATA = 1, A_RISE = 2, A_FALL = 3, A_PEND = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_ce = 1'b1;
  logic        bus_write = 1'b0;
  logic        bus_read = 1'b0;
  logic [23:0] bus_address_in = '0;
  logic [7:0]  bus_data_in = '0;
  logic [7:0]  bus_data_out;
  logic [7:0]  pin_in = '0;
  logic [7:0]  pin_out;
  logic [7:0]  pin_oe;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rv;

  gpio_port dut (
    .clk            (clk),
    .reset          (reset),
    .clk_ce         (clk_ce),
    .bus_write      (bus_write),
    .bus_read       (bus_read),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_data_out   (bus_data_out),
    .pin_in         (pin_in),
    .pin_out        (pin_out),
    .pin_oe         (pin_oe),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus write taking effect on the next rising edge.
  task automatic do_write(input int off, input logic [7:0] d);
    bus_address_in = BASE + 24'(off);
    bus_data_in    = d;
    bus_write      = 1'b1;
    @(posedge clk);
    #1;
    bus_write      = 1'b0;
  endtask

  // Combinational bus read with no clock edge involved.
  task automatic do_read(input int off, output logic [7:0] d);
    bus_address_in = BASE + 24'(off);
    bus_read       = 1'b1;
    #0.5;
    d              = bus_data_out;
    bus_read       = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++; if (pin_oe !== 8'h00) begin n_fail++; $display("FAIL reset_pin_oe: got %h expected 00", pin_oe); end
    n_checks++; if (pin_out !== 8'h00) begin n_fail++; $display("FAIL reset_pin_out: got %h expected 00", pin_out); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (bus_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus_idle: got %h expected 00", bus_data_out); end
    reset = 1'b1;
    tick(1);
    do_read(A_DIR, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL reset_dir: got %h expected 00", rv); end
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL reset_pend: got %h expected 00", rv); end
  endtask

  task automatic test_gpio_io();
    do_write(A_DIR, 8'h0F);
    do_write(A_DATA, 8'hA5);
    n_checks++; if (pin_oe !== 8'h0F) begin n_fail++; $display("FAIL io_pin_oe: got %h expected 0F", pin_oe); end
    n_checks++; if (pin_out !== 8'hA5) begin n_fail++; $display("FAIL io_pin_out: got %h expected A5", pin_out); end
    pin_in = 8'h30;
    tick(10);
    do_read(A_DATA, rv);
    n_checks++; if (rv !== 8'h35) begin n_fail++; $display("FAIL io_data_read: got %h expected 35", rv); end
    do_read(A_DIR + 5, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL io_unmapped: got %h expected 00", rv); end
    clk_ce = 1'b0;
    do_write(A_DIR, 8'hFF);
    clk_ce = 1'b1;
    do_read(A_DIR, rv);
    n_checks++; if (rv !== 8'h0F) begin n_fail++; $display("FAIL io_ce_blocks_write: got %h expected 0F", rv); end
    pin_in = 8'h00;
    do_write(A_DIR, 8'h00);
    do_write(A_DATA, 8'h00);
    tick(10);
  endtask

  task automatic test_debounce();
    // The pulse lasts 3 enabled samples, one short of the debounce count.
    pin_in[0] = 1'b1;
    tick(3);
    pin_in[0] = 1'b0;
    tick(8);
    do_read(A_DATA, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL deb_short_pulse: got %h expected 00", rv); end
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL deb_short_pend: got %h expected 00", rv); end
    // Held high: the 2-flop delay plus 4 samples means acceptance on edge 6.
    pin_in[0] = 1'b1;
    tick(5);
    do_read(A_DATA, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL deb_edge5: got %h expected 00", rv); end
    tick(1);
    do_read(A_DATA, rv);
    n_checks++; if (rv !== 8'h01) begin n_fail++; $display("FAIL deb_edge6: got %h expected 01", rv); end
    pin_in[0] = 1'b0;
    tick(8);
  endtask

  task automatic test_irq();
    do_write(A_RISE, 8'h01);
    pin_in[0] = 1'b1;
    tick(6);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h01) begin n_fail++; $display("FAIL irq_pend_set: got %h expected 01", rv); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_not_yet: got %b expected 0", irq); end
    tick(1);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_asserted: got %b expected 1", irq); end
    do_write(A_PEND, 8'h01);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL irq_w1c: got %h expected 00", rv); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag: got %b expected 1", irq); end
    tick(1);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    pin_in[0] = 1'b0;
    tick(8);
  endtask

  task automatic test_w1c_collision();
    pin_in[0] = 1'b1;
    tick(5);
    do_write(A_PEND, 8'h01);   // lands on the same edge as the rise
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h01) begin n_fail++; $display("FAIL coll_set_wins: got %h expected 01", rv); end
    do_write(A_PEND, 8'h00);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h01) begin n_fail++; $display("FAIL coll_w0_noop: got %h expected 01", rv); end
    do_write(A_PEND, 8'h01);
    tick(2);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL coll_clear: got %h expected 00", rv); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL coll_irq: got %b expected 0", irq); end
    pin_in[0] = 1'b0;
    tick(8);
  endtask

  task automatic test_dir_masked();
    do_write(A_FALL, 8'h80);
    do_write(A_DIR, 8'h80);
    pin_in[7] = 1'b1;
    tick(8);
    pin_in[7] = 1'b0;
    tick(8);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL mask_output_pin: got %h expected 00", rv); end
    do_write(A_DIR, 8'h00);
    tick(2);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL mask_dir_switch: got %h expected 00", rv); end
    pin_in[7] = 1'b1;
    tick(8);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL mask_rise_disabled: got %h expected 00", rv); end
    pin_in[7] = 1'b0;
    tick(8);
    do_read(A_PEND, rv);
    n_checks++; if (rv !== 8'h80) begin n_fail++; $display("FAIL mask_fall_set: got %h expected 80", rv); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_fall_irq: got %b expected 1", irq); end
    do_write(A_PEND, 8'h80);
    do_write(A_FALL, 8'h00);
    tick(2);
  endtask

  task automatic test_reset_async();
    do_write(A_DIR, 8'hF0);
    do_write(A_DATA, 8'hA5);
    pin_in[0] = 1'b1;
    tick(8);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ar_irq_before: got %b expected 1", irq); end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #0.5;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ar_irq: got %b expected 0", irq); end
    n_checks++; if (pin_oe !== 8'h00) begin n_fail++; $display("FAIL ar_pin_oe: got %h expected 00", pin_oe); end
    n_checks++; if (pin_out !== 8'h00) begin n_fail++; $display("FAIL ar_pin_out: got %h expected 00", pin_out); end
    for (int a = 0; a < 5; a++) begin
      do_read(a, rv);
      n_checks++; if (rv !== 8'h00) begin n_fail++; $display("FAIL ar_reg%0d: got %h expected 00", a, rv); end
    end
    pin_in = 8'h00;
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_gpio_io();
    test_debounce();
    test_irq();
    test_w1c_collision();
    test_dir_masked();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
